visible_watermarking: RTL and testbench
=======================================

Name: visible_watermarking

Overview:
- APB-slave accelerator that applies a visible watermark to a square greyscale image.
- Software loads the parameters, the primary image and the watermark image into an internal word memory over APB, then writes a start command.
- The block splits the image into M×M blocks and classifies each block as smooth or textured from its pixel range.
- It emits each output pixel = alpha·P + beta·W (fixed-point, saturated) on a streaming pixel port.

Parameters:
- Amba_Word, 16, APB data width.
- Amba_Addr_Depth, 20, memory address width (PADDR is Amba_Addr_Depth+1 bits).
- Data_Depth, 8, pixel bit depth.
- Block_Depth, 7, width of intra-block row/column counters (block side ≤ 72).
- Max_Block_Size, 5184, maximum pixels per block (72²).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- PENABLE, input, 1, APB enable.
- PSEL, input, 1, APB select.
- PWRITE, input, 1, 1 = write, 0 = read.
- PADDR, input, Amba_Addr_Depth+1, word address.
- PWDATA, input, Amba_Word, write data.
- PRDATA, output, Amba_Word, read data.
- Pixel_Data, output, Data_Depth, watermarked pixel.
- new_pixel, output, 1, one-cycle strobe marking Pixel_Data valid.
- Image_Done, output, 1, whole image emitted.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; PRDATA, Pixel_Data, new_pixel, Image_Done and all counters cleared. Memory contents are undefined and need not be cleared.
- APB write: performed on any rising edge with PSEL & PENABLE & PWRITE. No separate setup cycle is required, so back-to-back writes occur one per cycle. The memory word at PADDR receives PWDATA.
- APB read: with PSEL & PENABLE & !PWRITE, PRDATA is registered on the edge and holds the word at PADDR.
  - Address 0 reads status instead: bit0 = busy, bit1 = Image_Done, other bits 0.
- Address map:
  - 0: control; writing 1 in IDLE or DONE starts processing.
  - 1: Iwhite.
  - 2: Np (image side, pixels).
  - 3: Nw (watermark side; must equal Np).
  - 4: M (blocks per side).
  - 5: Bthr.
  - 6: Amin.
  - 7: Amax.
  - 8: Bmin.
  - 9: Bmax.
  - 10 .. 10+Np²−1: primary pixels, row-major.
  - 10+Np² .. 10+2Np²−1: watermark pixels, row-major.
  - Pixel/parameter values use PWDATA[Data_Depth-1:0]; Np, Nw and M use the full word.
- Block side B = Np/M. Software guarantees M divides Np, B ≤ 72 and Nw = Np. No hardware checks.
- While busy, all APB writes are ignored; reads are still served.
- FSM states:
  - IDLE: wait for start.
  - SCAN: read the B² primary pixels of the current block; track min and max.
  - CALC: 1 cycle; range = max − min. If range ≤ Bthr (smooth): alpha = Amax, beta = Bmin. Otherwise (textured): alpha = Amin, beta = Bmax.
  - EMIT: for each block pixel, out = (alpha·P + beta·W) >> 7, unsigned with a ≥17-bit intermediate; if out > Iwhite then out = Iwhite.
  - After EMIT, go to the next block: SCAN again, or DONE after the last block.
  - DONE: Image_Done = 1, held until the next start or reset.
- Block order: blocks row-major; pixels within a block row-major. Memory reads have 1-cycle latency.
- new_pixel is asserted for exactly B² consecutive cycles per block, with Pixel_Data valid in the same cycle. Between blocks it is low for at most B²+4 cycles. Pixel_Data holds its last value when new_pixel is low.
- Total new_pixel pulses per image = Np².
- Image_Done rises the cycle after the final new_pixel.
- Start while busy is ignored. Start in DONE clears Image_Done and reprocesses with the current memory contents.
- Reset mid-operation aborts immediately to IDLE with outputs cleared.

Test Plan:
- Load Iwhite=255, Np=Nw=4, M=2, Bthr=20, Amin=83, Amax=96, Bmin=25, Bmax=31, then start by writing 1 at address 0 -> exactly 16 new_pixel pulses followed by Image_Done=1.
- Block 0 primary 100,105,110,108 (smooth, range 10), all W=200 -> first pixel (96·100+25·200)>>7 = 114.
- Block 1 primary 10,50,90,130 (textured, range 120), W=0 -> outputs 6,32,58,84.
- Set Amax=120, Bmin=31; smooth block P=W=255 -> (151·255)>>7 = 300, saturated to 255. Repeat with Iwhite=200 -> 200.
- APB read addr 2 after load -> PRDATA=4. Read addr 0 while busy -> bit0=1. Writes during busy -> memory unchanged.
- Assert rst=0 mid-EMIT -> new_pixel, Image_Done and Pixel_Data go to 0 immediately. A fresh start reproduces the full 16-pixel output.

Source files
------------

// File: rtl/visible_watermarking.sv
`default_nettype none
// ============================================================================
// Module      : visible_watermarking
// Description : APB-loaded accelerator that blends a watermark into a square
//               greyscale image block by block and streams the result.
// Revision    : 1.0 - initial release
// ============================================================================
module visible_watermarking #(
    parameter int Amba_Word       = 16,
    parameter int Amba_Addr_Depth = 20,
    parameter int Data_Depth      = 8,
    parameter int Block_Depth     = 7,
    parameter int Max_Block_Size  = 5184
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PENABLE,
    input  logic                     PSEL,
    input  logic                     PWRITE,
    input  logic [Amba_Addr_Depth:0] PADDR,
    input  logic [Amba_Word-1:0]     PWDATA,
    output logic [Amba_Word-1:0]     PRDATA,
    output logic [Data_Depth-1:0]    Pixel_Data,
    output logic                     new_pixel,
    output logic                     Image_Done
);

    localparam int AW        = Amba_Addr_Depth + 1;
    localparam int MEM_WORDS = 1 << Amba_Addr_Depth;
    localparam int SW        = 2 * Data_Depth + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [AW-1:0] PIX_BASE = AW'(10);

    logic [Amba_Word-1:0]   mem [0:MEM_WORDS-1];

    logic [2:0]             r_state;
    logic [Data_Depth-1:0]  r_iwhite, r_bthr, r_amin, r_amax, r_bmin, r_bmax;
    logic [Amba_Word-1:0]   r_np, r_m;
    logic [Block_Depth-1:0] r_b, r_col, r_row;
    logic [Amba_Word-1:0]   r_blk_c, r_blk_r;
    logic [AW-1:0]          r_wbase, r_brow_step, r_brow_base, r_blk_base, r_line;
    logic                   r_gen_active, r_pv, r_plast;
    logic [Data_Depth-1:0]  r_min, r_max, r_alpha, r_beta;
    logic [Amba_Word-1:0]   r_p_q, r_w_q;

    logic                       w_busy, w_apb_wr, w_apb_rd, w_start, w_issue;
    logic                       w_col_end, w_row_end, w_last_blk_c, w_last_blk_r;
    logic [Amba_Addr_Depth-1:0] w_addr;
    logic [AW-1:0]              w_offset, w_p_addr, w_w_addr;
    logic [AW-1:0]              w_next_brow, w_next_blk_base;
    logic [Amba_Word-1:0]       w_b_calc, w_status;
    logic [2*Amba_Word-1:0]     w_np_sq, w_brow_step;
    logic [Data_Depth-1:0]      w_p_pix, w_w_pix, w_range, w_out;
    logic [SW-1:0]              w_sum, w_scaled;
    logic                       w_unused;

    assign w_busy   = (r_state == S_SCAN) || (r_state == S_CALC) || (r_state == S_EMIT);
    assign w_apb_wr = PSEL && PENABLE && PWRITE && !w_busy;
    assign w_apb_rd = PSEL && PENABLE && !PWRITE;
    assign w_addr   = PADDR[Amba_Addr_Depth-1:0];
    assign w_start  = w_apb_wr && (PADDR == '0) && (PWDATA == Amba_Word'(1));
    assign w_status = {{(Amba_Word-2){1'b0}}, Image_Done, w_busy};

    // One address walker serves both the min/max scan and the emit pass.
    assign w_issue   = r_gen_active && ((r_state == S_SCAN) || (r_state == S_EMIT));
    assign w_col_end = (r_col == r_b - 1'b1);
    assign w_row_end = (r_row == r_b - 1'b1);
    assign w_offset  = r_line + AW'(r_col);
    assign w_p_addr  = PIX_BASE + w_offset;
    assign w_w_addr  = r_wbase + w_offset;

    assign w_b_calc    = r_np / r_m;
    assign w_np_sq     = {{Amba_Word{1'b0}}, r_np} * {{Amba_Word{1'b0}}, r_np};
    assign w_brow_step = {{Amba_Word{1'b0}}, w_b_calc} * {{Amba_Word{1'b0}}, r_np};

    assign w_last_blk_c    = (r_blk_c == r_m - 1'b1);
    assign w_last_blk_r    = (r_blk_r == r_m - 1'b1);
    assign w_next_brow     = r_brow_base + r_brow_step;
    assign w_next_blk_base = w_last_blk_c ? w_next_brow : (r_blk_base + AW'(r_b));

    assign w_p_pix = r_p_q[Data_Depth-1:0];
    assign w_w_pix = r_w_q[Data_Depth-1:0];
    assign w_range = r_max - r_min;

    // alpha/beta are Q1.7 weights; the 17-bit sum cannot overflow for 8-bit inputs.
    assign w_sum    = SW'(r_alpha) * SW'(w_p_pix) + SW'(r_beta) * SW'(w_w_pix);
    assign w_scaled = w_sum >> 7;
    assign w_out    = (w_scaled > SW'(r_iwhite)) ? r_iwhite : w_scaled[Data_Depth-1:0];

    assign w_unused = ^{PADDR[Amba_Addr_Depth], w_p_addr[AW-1], w_w_addr[AW-1],
                        r_p_q[Amba_Word-1:Data_Depth], r_w_q[Amba_Word-1:Data_Depth],
                        1'(Max_Block_Size)};

    // Storage and parameter shadows survive reset so a restart reuses the loaded image.
    always_ff @(posedge clk) begin
        if (w_apb_wr && (PADDR != '0)) begin
            mem[w_addr] <= PWDATA;
            case (PADDR)
                AW'(1):  r_iwhite <= PWDATA[Data_Depth-1:0];
                AW'(2):  r_np     <= PWDATA;
                AW'(4):  r_m      <= PWDATA;
                AW'(5):  r_bthr   <= PWDATA[Data_Depth-1:0];
                AW'(6):  r_amin   <= PWDATA[Data_Depth-1:0];
                AW'(7):  r_amax   <= PWDATA[Data_Depth-1:0];
                AW'(8):  r_bmin   <= PWDATA[Data_Depth-1:0];
                AW'(9):  r_bmax   <= PWDATA[Data_Depth-1:0];
                default: ;
            endcase
        end
        r_p_q <= mem[w_p_addr[Amba_Addr_Depth-1:0]];
        r_w_q <= mem[w_w_addr[Amba_Addr_Depth-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            PRDATA       <= '0;
            Pixel_Data   <= '0;
            new_pixel    <= 1'b0;
            Image_Done   <= 1'b0;
            r_b          <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_blk_c      <= '0;
            r_blk_r      <= '0;
            r_wbase      <= '0;
            r_brow_step  <= '0;
            r_brow_base  <= '0;
            r_blk_base   <= '0;
            r_line       <= '0;
            r_gen_active <= 1'b0;
            r_pv         <= 1'b0;
            r_plast      <= 1'b0;
            r_min        <= '1;
            r_max        <= '0;
            r_alpha      <= '0;
            r_beta       <= '0;
        end else begin
            new_pixel <= 1'b0;
            r_pv      <= w_issue;
            r_plast   <= w_issue && w_col_end && w_row_end;

            if (w_apb_rd) begin
                PRDATA <= (PADDR == '0) ? w_status : mem[w_addr];
            end

            if (w_issue) begin
                if (w_col_end) begin
                    r_col  <= '0;
                    r_line <= r_line + AW'(r_np);
                    if (w_row_end) begin
                        r_gen_active <= 1'b0;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        Image_Done <= 1'b1;
                    end
                    if (w_start) begin
                        Image_Done   <= 1'b0;
                        r_b          <= Block_Depth'(w_b_calc);
                        r_wbase      <= PIX_BASE + AW'(w_np_sq);
                        r_brow_step  <= AW'(w_brow_step);
                        r_brow_base  <= '0;
                        r_blk_base   <= '0;
                        r_blk_c      <= '0;
                        r_blk_r      <= '0;
                        r_line       <= '0;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_gen_active <= 1'b1;
                        r_min        <= '1;
                        r_max        <= '0;
                        r_state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_pv) begin
                        if (w_p_pix < r_min) r_min <= w_p_pix;
                        if (w_p_pix > r_max) r_max <= w_p_pix;
                        if (r_plast) r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_range <= r_bthr) begin
                        r_alpha <= r_amax;
                        r_beta  <= r_bmin;
                    end else begin
                        r_alpha <= r_amin;
                        r_beta  <= r_bmax;
                    end
                    r_line       <= r_blk_base;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_gen_active <= 1'b1;
                    r_state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (r_pv) begin
                        new_pixel  <= 1'b1;
                        Pixel_Data <= w_out;
                        if (r_plast) begin
                            if (w_last_blk_c && w_last_blk_r) begin
                                r_state <= S_DONE;
                            end else begin
                                if (w_last_blk_c) begin
                                    r_blk_c     <= '0;
                                    r_blk_r     <= r_blk_r + 1'b1;
                                    r_brow_base <= w_next_brow;
                                end else begin
                                    r_blk_c <= r_blk_c + 1'b1;
                                end
                                r_blk_base   <= w_next_blk_base;
                                r_line       <= w_next_blk_base;
                                r_col        <= '0;
                                r_row        <= '0;
                                r_gen_active <= 1'b1;
                                r_min        <= '1;
                                r_max        <= '0;
                                r_state      <= S_SCAN;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_visible_watermarking.sv
`default_nettype none
// ============================================================================
// Module      : tb_visible_watermarking
// Description : Directed self-checking bench for visible_watermarking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_visible_watermarking;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [20:0] PADDR   = '0;
    logic [15:0] PWDATA  = '0;
    logic [15:0] PRDATA;
    logic [7:0]  Pixel_Data;
    logic        new_pixel;
    logic        Image_Done;

    int checks = 0;
    int passes = 0;
    int cyc;
    logic [15:0] rd;
    logic [7:0]  got [16];

    // 4x4 image, 2x2 blocks: block0 smooth, block1 textured, block2 flat white, block3 textured.
    int img_p [16] = '{100, 105,  10,  50,
                       110, 108,  90, 130,
                       255, 255,   0, 255,
                       255, 255,   0, 255};
    int img_w [16] = '{200, 200,   0,   0,
                       200, 200,   0,   0,
                       255, 255, 128, 128,
                       255, 255,  64,  64};

    // Stream order is block-major: block0, block1, block2, block3.
    logic [7:0] exp_px [3][16] = '{
        '{114, 117, 121, 120,   6,  32,  58,  84, 241, 241, 241, 241,  31, 196,  15, 180},
        '{142, 146, 151, 149,   6,  32,  58,  84, 255, 255, 255, 255,  31, 196,  15, 180},
        '{142, 146, 151, 149,   6,  32,  58,  84, 200, 200, 200, 200,  31, 196,  15, 180}};

    visible_watermarking dut (
        .clk        (clk),
        .rst        (rst),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .Pixel_Data (Pixel_Data),
        .new_pixel  (new_pixel),
        .Image_Done (Image_Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic apb_write(input int addr, input int data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = 21'(addr); PWDATA = 16'(data);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input int addr, output logic [15:0] data);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 21'(addr);
        @(posedge clk); #1;
        data = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Called right after the start write; collects the stream and checks framing.
    task automatic run_capture(input int run);
        int   npix;
        int   run_len;
        int   bad;
        int   n;
        logic prev;
        logic done_prev;
        npix = 0; run_len = 0; bad = 0; n = 0; prev = 1'b0; done_prev = 1'b0;
        while (Image_Done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (new_pixel === 1'b1) begin
                if (npix < 16) got[npix] = Pixel_Data;
                npix++;
                run_len++;
            end else begin
                if (run_len != 0 && run_len != 4) bad++;
                run_len = 0;
            end
            if (Image_Done === 1'b1) done_prev = prev;
            prev = new_pixel;
        end
        check($sformatf("run%0d_done", run), 32'(Image_Done), 32'd1);
        check($sformatf("run%0d_px_count", run), npix, 16);
        check($sformatf("run%0d_done_after_last", run), 32'(done_prev), 32'd1);
        check($sformatf("run%0d_block_runs", run), bad, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("run%0d_px%0d", run, i), 32'(got[i]), 32'(exp_px[run][i]));
        end
        repeat (3) @(negedge clk);
        check($sformatf("run%0d_done_hold", run), 32'(Image_Done), 32'd1);
        check($sformatf("run%0d_np_idle", run), 32'(new_pixel), 32'd0);
        check($sformatf("run%0d_px_hold", run), 32'(Pixel_Data), 32'(exp_px[run][15]));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_prdata", 32'(PRDATA), 32'd0);
        check("rst_pixel", 32'(Pixel_Data), 32'd0);
        check("rst_new_pixel", 32'(new_pixel), 32'd0);
        check("rst_done", 32'(Image_Done), 32'd0);
        @(negedge clk); rst = 1'b1;
        apb_read(0, rd);
        check("idle_status", 32'(rd), 32'd0);

        // Load parameters and image
        apb_write(1, 255); apb_write(2, 4);  apb_write(3, 4);  apb_write(4, 2);
        apb_write(5, 20);  apb_write(6, 83); apb_write(7, 96); apb_write(8, 25);
        apb_write(9, 31);
        for (int i = 0; i < 16; i++) begin
            apb_write(10 + i, img_p[i]);
            apb_write(26 + i, img_w[i]);
        end
        apb_read(2, rd);
        check("read_np", 32'(rd), 32'd4);
        apb_read(27, rd);
        check("read_w1", 32'(rd), 32'd200);

        // Run 0: baseline weights
        apb_write(0, 1);
        run_capture(0);
        apb_read(0, rd);
        check("done_status", 32'(rd), 32'd2);

        // Run 1: stronger smooth weights saturate the white block; restart from DONE
        apb_write(7, 120); apb_write(8, 31);
        apb_write(0, 1);
        check("restart_clears_done", 32'(Image_Done), 32'd0);
        run_capture(1);

        // Run 2: lower white level clips to 200
        apb_write(1, 200);
        apb_write(0, 1);
        run_capture(2);

        // Busy behaviour: status, ignored writes
        apb_write(0, 1);
        apb_read(0, rd);
        check("busy_status", 32'(rd), 32'd1);
        apb_write(10, 0);
        apb_write(2, 9);
        apb_write(0, 1);
        cyc = 0;
        while (Image_Done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_run_done", 32'(Image_Done), 32'd1);
        apb_read(10, rd);
        check("busy_write_px_ignored", 32'(rd), 32'd100);
        apb_read(2, rd);
        check("busy_write_np_ignored", 32'(rd), 32'd4);

        // Asynchronous reset in the middle of emission
        apb_write(0, 1);
        cyc = 0;
        while (new_pixel !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("emit_started", 32'(new_pixel), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_new_pixel", 32'(new_pixel), 32'd0);
        check("arst_pixel", 32'(Pixel_Data), 32'd0);
        check("arst_done", 32'(Image_Done), 32'd0);
        @(negedge clk); rst = 1'b1;
        apb_read(0, rd);
        check("arst_status", 32'(rd), 32'd0);

        // Fresh start after reset reproduces the full image
        apb_write(0, 1);
        run_capture(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
